// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch and decode stages of the 8-bit core.
//   fetch_state_t   - fetch FSM state encoding
//   TWO_BYTE_PREFIX - opcode high nibble that marks an opcode + immediate instruction
//   two_byte()      - instruction length rule (decode uses the same function)
//   OPCODE_W/IMM_W  - IF/ID bundle field widths
package core_pkg;

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_IMM = 2'd1,
      INT_VEC   = 2'd2
   } fetch_state_t;

   localparam logic [3:0]  TWO_BYTE_PREFIX = 4'hC;
   localparam int unsigned OPCODE_W        = 8;
   localparam int unsigned IMM_W           = 8;

   function automatic logic two_byte(input logic [OPCODE_W-1:0] op);
      return op[7:4] == TWO_BYTE_PREFIX;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   clk, rst (sync, active-low) - clock and reset
//   hold                        - keep current contents (lower priority than clear)
//   clear                       - load an empty bubble (all fields zero)
//   d_opcode/d_imm/d_pc_next    - instruction loaded with valid=1 when neither hold nor clear
//   valid/opcode/imm/pc_next    - register outputs
module ifid_reg
   import core_pkg::*;
#(
   parameter int unsigned PC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hold,
   input  logic                clear,
   input  logic [OPCODE_W-1:0] d_opcode,
   input  logic [IMM_W-1:0]    d_imm,
   input  logic [PC_W-1:0]     d_pc_next,
   output logic                valid,
   output logic [OPCODE_W-1:0] opcode,
   output logic [IMM_W-1:0]    imm,
   output logic [PC_W-1:0]     pc_next
);

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         valid   <= 1'b0;
         opcode  <= '0;
         imm     <= '0;
         pc_next <= '0;
      end else if (!hold) begin
         valid   <= 1'b1;
         opcode  <= d_opcode;
         imm     <= d_imm;
         pc_next <= d_pc_next;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; owns the PC, reads the byte-wide IM,
// assembles opcode+immediate instructions and drives the IF/ID register.
// Ports:
//   clk, rst (sync, active-low)
//   imem_addr/imem_data         - combinational IM read port
//   stall                       - HDU stall: freeze PC, FSM, hold and IF/ID
//   redirect/redirect_pc        - flush and load a new PC (beats stall)
//   interrupt                   - level request; int_ack pulses when the vector is read
//   int_ret_pc                  - PC of the next unissued instruction, valid with int_ack
//   ifid_valid/opcode/imm/pc_next - IF/ID register
//   pc_debug                    - current PC
// Optional: `define FETCH_PERF_CNT_EN adds stall_cnt/flush_cnt (saturating, 16 bit).
module fetch_stage
   import core_pkg::*;
#(
   parameter int unsigned     PC_W         = 8,
   parameter logic [PC_W-1:0] RESET_PC     = 8'h00,
   parameter logic [PC_W-1:0] INT_VEC_ADDR = 8'h01
) (
   input  logic                clk,
   input  logic                rst,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [7:0]          imem_data,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_W-1:0]     redirect_pc,
   input  logic                interrupt,
   output logic                int_ack,
   output logic [PC_W-1:0]     int_ret_pc,
   output logic                ifid_valid,
   output logic [OPCODE_W-1:0] ifid_opcode,
   output logic [IMM_W-1:0]    ifid_imm,
   output logic [PC_W-1:0]     ifid_pc_next,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]         stall_cnt,
   output logic [15:0]         flush_cnt,
`endif
   output logic [PC_W-1:0]     pc_debug
);

   fetch_state_t        state, state_nxt;
   logic [PC_W-1:0]     pc, pc_nxt, pc_inc;
   logic [OPCODE_W-1:0] hold_op, hold_op_nxt;
   logic [PC_W-1:0]     ret_pc_nxt;
   // Set when the vector is taken; blocks re-entry until the ISR's first opcode is fetched.
   logic                int_block, int_block_nxt;

   logic                ifid_hold, ifid_clear;
   logic [OPCODE_W-1:0] d_opcode;
   logic [IMM_W-1:0]    d_imm;

   assign pc_inc    = pc + PC_W'(1);
   assign imem_addr = (state == INT_VEC) ? INT_VEC_ADDR : pc;
   assign pc_debug  = pc;
   assign ifid_hold = stall && !redirect;

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      hold_op_nxt   = hold_op;
      ret_pc_nxt    = int_ret_pc;
      int_block_nxt = int_block;
      ifid_clear    = 1'b0;
      d_opcode      = imem_data;
      d_imm         = '0;
      int_ack       = 1'b0;

      if (redirect) begin
         pc_nxt      = redirect_pc;
         state_nxt   = FETCH_OP;
         hold_op_nxt = '0;
         ifid_clear  = 1'b1;
      end else if (!stall) begin
         unique case (state)
            FETCH_OP: begin
               if (interrupt && !int_block) begin
                  ret_pc_nxt = pc;
                  state_nxt  = INT_VEC;
                  ifid_clear = 1'b1;
               end else begin
                  int_block_nxt = 1'b0;
                  pc_nxt        = pc_inc;
                  if (two_byte(imem_data)) begin
                     hold_op_nxt = imem_data;
                     state_nxt   = FETCH_IMM;
                     ifid_clear  = 1'b1;
                  end
               end
            end
            FETCH_IMM: begin
               d_opcode  = hold_op;
               d_imm     = imem_data;
               pc_nxt    = pc_inc;
               state_nxt = FETCH_OP;
            end
            INT_VEC: begin
               pc_nxt        = PC_W'(imem_data);
               int_ack       = 1'b1;
               int_block_nxt = 1'b1;
               ifid_clear    = 1'b1;
               state_nxt     = FETCH_OP;
            end
            default: begin
               state_nxt  = FETCH_OP;
               ifid_clear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= FETCH_OP;
         pc         <= RESET_PC;
         hold_op    <= '0;
         int_ret_pc <= '0;
         int_block  <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         hold_op    <= hold_op_nxt;
         int_ret_pc <= ret_pc_nxt;
         int_block  <= int_block_nxt;
      end
   end

   ifid_reg #(.PC_W(PC_W)) u_ifid (
      .clk       (clk),
      .rst       (rst),
      .hold      (ifid_hold),
      .clear     (ifid_clear),
      .d_opcode  (d_opcode),
      .d_imm     (d_imm),
      .d_pc_next (pc_inc),
      .valid     (ifid_valid),
      .opcode    (ifid_opcode),
      .imm       (ifid_imm),
      .pc_next   (ifid_pc_next)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && !redirect && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
         if (redirect && flush_cnt != '1)           flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic       clk = 1'b0;
   logic       rst, stall, redirect, interrupt;
   logic [7:0] redirect_pc;
   logic [7:0] imem_addr, imem_data;
   logic       int_ack, ifid_valid;
   logic [7:0] int_ret_pc, ifid_opcode, ifid_imm, ifid_pc_next, pc_debug;

   logic [7:0] mem [256];
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   fetch_stage #(.PC_W(8), .RESET_PC(8'h00), .INT_VEC_ADDR(8'h01)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .interrupt    (interrupt),
      .int_ack      (int_ack),
      .int_ret_pc   (int_ret_pc),
      .ifid_valid   (ifid_valid),
      .ifid_opcode  (ifid_opcode),
      .ifid_imm     (ifid_imm),
      .ifid_pc_next (ifid_pc_next),
      .pc_debug     (pc_debug)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: instruction-level view. Bytes of the instruction being assembled
   // sit in a queue; an instruction retires when the queue holds as many
   // bytes as the first byte's length says.
   logic [7:0] m_pc, m_ret, e_op, e_imm, e_pcn;
   logic       m_vec, m_block, e_valid;
   logic [7:0] part[$];
   bit         chk_en = 0;

   function automatic int ilen(input logic [7:0] op);
      return (op >= 8'hC0 && op <= 8'hCF) ? 2 : 1;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_pc = 8'h00; m_ret = 8'h00; m_vec = 0; m_block = 0;
         part.delete();
         e_valid = 0; e_op = 0; e_imm = 0; e_pcn = 0;
      end else if (redirect) begin
         m_pc = redirect_pc; m_vec = 0; part.delete(); e_valid = 0;
      end else if (stall) begin
         // everything frozen
      end else if (m_vec) begin
         m_pc = mem[8'h01]; m_vec = 0; m_block = 1; e_valid = 0;
      end else if (part.size() == 0 && interrupt && !m_block) begin
         m_ret = m_pc; m_vec = 1; e_valid = 0;
      end else begin
         part.push_back(mem[m_pc]);
         if (part.size() == 1) m_block = 0;
         m_pc = m_pc + 8'd1;
         if (part.size() == ilen(part[0])) begin
            e_valid = 1; e_op = part[0];
            e_imm = (part.size() == 2) ? part[1] : 8'h00;
            e_pcn = m_pc;
            part.delete();
         end else begin
            e_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_debug",   pc_debug,   m_pc);
         chk("imem_addr",  imem_addr,  m_vec ? 8'h01 : m_pc);
         chk("int_ack",    int_ack,    m_vec && !stall && !redirect);
         chk("int_ret_pc", int_ret_pc, m_ret);
         chk("ifid_valid", ifid_valid, e_valid);
         if (e_valid) begin
            chk("ifid_opcode",  ifid_opcode,  e_op);
            chk("ifid_imm",     ifid_imm,     e_imm);
            chk("ifid_pc_next", ifid_pc_next, e_pcn);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'hC5; mem[8'h01] = 8'h0A; mem[8'h02] = 8'h29;
      mem[8'h03] = 8'h11; mem[8'h04] = 8'hC3; mem[8'h05] = 8'h77;
      mem[8'h80] = 8'h22; mem[8'h20] = 8'hC7; mem[8'h21] = 8'h99;
      mem[8'h40] = 8'h33; mem[8'hFE] = 8'hC1; mem[8'hFF] = 8'h5A;
      rst = 0; stall = 0; redirect = 0; redirect_pc = 0; interrupt = 0;

      // reset
      step(); chk_en = 1; step();
      chk("rst_pc", pc_debug, 8'h00);
      chk("rst_valid", ifid_valid, 0);
      rst = 1;

      // two-byte C5 0A, then 29
      step(); chk("tb_bubble_pc", pc_debug, 8'h01); chk("tb_bubble_valid", ifid_valid, 0);
      step(); chk("tb_op", ifid_opcode, 8'hC5); chk("tb_imm", ifid_imm, 8'h0A);
      chk("tb_pcn", ifid_pc_next, 8'h02);
      mem[8'h01] = 8'h80;   // now serves as the interrupt vector

      // stall at PC=02
      stall = 1;
      step(); chk("stall_pc", pc_debug, 8'h02); chk("stall_op", ifid_opcode, 8'hC5);
      stall = 0;
      step(); chk("post_stall_op", ifid_opcode, 8'h29); chk("post_stall_pcn", ifid_pc_next, 8'h03);
      step();                 // 11 at 03
      step();                 // C3 at 04 -> FETCH_IMM, PC=05
      interrupt = 1;
      step(); chk("int_deferred_op", ifid_opcode, 8'hC3); chk("int_deferred_imm", ifid_imm, 8'h77);
      step(); chk("int_ret", int_ret_pc, 8'h06); chk("int_ack_hi", int_ack, 1);
      chk("int_vec_addr", imem_addr, 8'h01); chk("int_entry_valid", ifid_valid, 0);
      step(); chk("isr_pc", pc_debug, 8'h80); chk("int_ack_lo", int_ack, 0);
      step(); chk("isr_first_op", ifid_opcode, 8'h22);
      step(); chk("int_retake_ret", int_ret_pc, 8'h81);
      interrupt = 0;
      step();

      // redirect beats stall mid FETCH_IMM
      redirect = 1; redirect_pc = 8'h20;
      step(); redirect = 0;
      step();                 // C7 fetched, waiting on immediate
      stall = 1; redirect = 1; redirect_pc = 8'h40;
      step(); chk("redir_pc", pc_debug, 8'h40); chk("redir_valid", ifid_valid, 0);
      stall = 0; redirect = 0;
      step(); chk("redir_op", ifid_opcode, 8'h33); chk("redir_pcn", ifid_pc_next, 8'h41);

      // wrap across FE/FF
      redirect = 1; redirect_pc = 8'hFE;
      step(); redirect = 0;
      step();
      step(); chk("wrap_op", ifid_opcode, 8'hC1); chk("wrap_imm", ifid_imm, 8'h5A);
      chk("wrap_pcn", ifid_pc_next, 8'h00); chk("wrap_pc", pc_debug, 8'h00);

      // reset mid two-byte fetch
      redirect = 1; redirect_pc = 8'h20;
      step(); redirect = 0;
      step();
      rst = 0;
      step(); chk("midrst_pc", pc_debug, 8'h00); chk("midrst_valid", ifid_valid, 0);
      rst = 1;
      step(); step(); chk("midrst_op", ifid_opcode, 8'hC5); chk("midrst_imm", ifid_imm, 8'h80);

      // mixed traffic checked by the model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 300; i++) begin
         stall       = ($urandom_range(0, 5) == 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = 8'($urandom_range(0, 255));
         interrupt   = ($urandom_range(0, 7) == 0);
         step();
      end
      stall = 0; redirect = 0; interrupt = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
